// File: rtl/fp_div_seq.sv
// fp_div_seq: iterative IEEE-754 single-precision divider (restoring radix-2, one quotient bit per cycle).
// Optional build macro FP_DIV_EARLY_EXIT_EN stops iterating once the partial remainder reaches zero.
module fp_div_seq #(
  parameter int          ITER_BITS = 27,
  parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        in_ready,
  input  logic [31:0] fp_X,
  input  logic [31:0] fp_Y,
  input  logic [2:0]  r_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] fp_Z,
  output logic        ovrf,
  output logic        udrf,
  output logic        zer,
  output logic        inf,
  output logic        nan,
  output logic        dz
);
  localparam int QW = ITER_BITS;
  localparam int CW = $clog2(ITER_BITS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_ITER   = 3'd2,
    S_ROUND  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state_q;
  logic [31:0]        x_q;
  logic [31:0]        y_q;
  logic [2:0]         rm_q;
  logic               sign_q;
  logic signed [9:0]  e_q;
  logic [24:0]        rem_q;
  logic [23:0]        div_q;
  logic [QW-1:0]      q_q;
  logic [CW-1:0]      idx_q;
  logic [31:0]        zp_q;
  logic [5:0]         flp_q;
  logic [31:0]        fpz_q;
  logic [5:0]         flags_q;
  logic               out_valid_q;
  logic               in_ready_q;

  // Operand classification; exponent zero is treated as zero (subnormals flushed).
  logic x_zero, y_zero, x_inf, y_inf, x_nan, y_nan, res_sign;
  assign x_zero   = (x_q[30:23] == 8'd0);
  assign y_zero   = (y_q[30:23] == 8'd0);
  assign x_inf    = (x_q[30:23] == 8'hFF) && (x_q[22:0] == 23'd0);
  assign y_inf    = (y_q[30:23] == 8'hFF) && (y_q[22:0] == 23'd0);
  assign x_nan    = (x_q[30:23] == 8'hFF) && (x_q[22:0] != 23'd0);
  assign y_nan    = (y_q[30:23] == 8'hFF) && (y_q[22:0] != 23'd0);
  assign res_sign = x_q[31] ^ y_q[31];

  // Special-case results; flag vector is {ovrf, udrf, zer, inf, nan, dz}.
  logic        sp_hit;
  logic [31:0] sp_z_d;
  logic [5:0]  sp_fl_d;
  always_comb begin
    sp_hit  = 1'b1;
    sp_z_d  = 32'd0;
    sp_fl_d = 6'd0;
    if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) begin
      sp_z_d  = CANON_NAN;
      sp_fl_d = 6'b000010;
    end else if (x_inf) begin
      sp_z_d  = {res_sign, 8'hFF, 23'd0};
      sp_fl_d = 6'b000100;
    end else if (y_zero) begin
      sp_z_d  = {res_sign, 8'hFF, 23'd0};
      sp_fl_d = 6'b000101;
    end else if (x_zero || y_inf) begin
      sp_z_d  = {res_sign, 31'd0};
      sp_fl_d = 6'b001000;
    end else begin
      sp_hit = 1'b0;
    end
  end

  // One restoring step; the difference always fits 24 bits when it is taken.
  logic        ge;
  logic [23:0] diff;
  logic [23:0] rem_sub;
  logic [24:0] rem_d;
  logic        iter_last;
  assign ge      = (rem_q >= {1'b0, div_q});
  assign diff    = rem_q[23:0] - div_q;
  assign rem_sub = ge ? diff : rem_q[23:0];
  assign rem_d   = {rem_sub, 1'b0};
`ifdef FP_DIV_EARLY_EXIT_EN
  assign iter_last = (idx_q == {CW{1'b0}}) || (rem_sub == 24'd0);
`else
  assign iter_last = (idx_q == {CW{1'b0}});
`endif

  // Normalize so the hidden bit sits just above norm; exponent follows.
  logic [QW-2:0]     norm;
  logic signed [9:0] e_n;
  always_comb begin
    if (q_q[QW-1]) begin
      norm = q_q[QW-2:0];
      e_n  = e_q;
    end else begin
      norm = {q_q[QW-3:0], 1'b0};
      e_n  = e_q - 10'sd1;
    end
  end

  logic [22:0]       mant;
  logic              guard, sticky, inc;
  logic [23:0]       sum;
  logic signed [9:0] e_r;
  assign mant   = norm[QW-2 -: 23];
  assign guard  = norm[QW-25];
  assign sticky = (|norm[QW-26:0]) | (|rem_q);
  assign sum    = {1'b0, mant} + {23'd0, inc};
  assign e_r    = e_n + $signed({9'd0, sum[23]});

  // Rounding increment decision by mode; unknown encodings round to nearest even.
  always_comb begin
    inc = 1'b0;
    case (rm_q)
      3'b001:  inc = 1'b0;
      3'b010:  inc = sign_q & (guard | sticky);
      3'b011:  inc = ~sign_q & (guard | sticky);
      3'b100:  inc = guard;
      default: inc = guard & (sticky | mant[0]);
    endcase
  end

  // Final packing with overflow saturation policy and flush-to-zero underflow.
  logic [31:0] rd_z_d;
  logic [5:0]  rd_fl_d;
  always_comb begin
    rd_z_d  = {sign_q, e_r[7:0], sum[22:0]};
    rd_fl_d = 6'd0;
    if (e_r >= 10'sd255) begin
      rd_fl_d = 6'b100100;
      case (rm_q)
        3'b001:  rd_z_d = {sign_q, 31'h7F7FFFFF};
        3'b010:  rd_z_d = sign_q ? {1'b1, 8'hFF, 23'd0} : {1'b0, 31'h7F7FFFFF};
        3'b011:  rd_z_d = sign_q ? {1'b1, 31'h7F7FFFFF} : {1'b0, 8'hFF, 23'd0};
        default: rd_z_d = {sign_q, 8'hFF, 23'd0};
      endcase
    end else if (e_r <= 10'sd0) begin
      rd_fl_d = 6'b011000;
      rd_z_d  = {sign_q, 31'd0};
    end else begin
      rd_fl_d = 6'd0;
    end
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= 32'd0;
      y_q         <= 32'd0;
      rm_q        <= 3'd0;
      sign_q      <= 1'b0;
      e_q         <= 10'sd0;
      rem_q       <= 25'd0;
      div_q       <= 24'd0;
      q_q         <= {QW{1'b0}};
      idx_q       <= {CW{1'b0}};
      zp_q        <= 32'd0;
      flp_q       <= 6'd0;
      fpz_q       <= 32'd0;
      flags_q     <= 6'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            x_q        <= fp_X;
            y_q        <= fp_Y;
            rm_q       <= r_mode;
            in_ready_q <= 1'b0;
            state_q    <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          sign_q <= res_sign;
          if (sp_hit) begin
            zp_q    <= sp_z_d;
            flp_q   <= sp_fl_d;
            state_q <= S_DONE;
          end else begin
            rem_q   <= {2'b01, x_q[22:0]};
            div_q   <= {1'b1, y_q[22:0]};
            e_q     <= $signed({2'b00, x_q[30:23]}) - $signed({2'b00, y_q[30:23]}) + 10'sd127;
            q_q     <= {QW{1'b0}};
            idx_q   <= CW'(ITER_BITS - 1);
            state_q <= S_ITER;
          end
        end
        S_ITER: begin
          rem_q        <= rem_d;
          q_q[idx_q]   <= ge;
          if (iter_last) begin
            state_q <= S_ROUND;
          end else begin
            idx_q <= idx_q - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        S_ROUND: begin
          zp_q    <= rd_z_d;
          flp_q   <= rd_fl_d;
          state_q <= S_DONE;
        end
        S_DONE: begin
          if (!out_valid_q) begin
            fpz_q       <= zp_q;
            flags_q     <= flp_q;
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign fp_Z      = fpz_q;
  assign ovrf      = flags_q[5];
  assign udrf      = flags_q[4];
  assign zer       = flags_q[3];
  assign inf       = flags_q[2];
  assign nan       = flags_q[1];
  assign dz        = flags_q[0];
endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: directed vector table plus backpressure and mid-operation reset sequences.
module tb_fp_div_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_ready;
  logic [31:0] fp_X;
  logic [31:0] fp_Y;
  logic [2:0]  r_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] fp_Z;
  logic        ovrf, udrf, zer, inf, nan, dz;

  int n_checks;
  int n_errors;

  fp_div_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_ready(in_ready),
    .fp_X(fp_X), .fp_Y(fp_Y), .r_mode(r_mode),
    .out_valid(out_valid), .out_ready(out_ready), .fp_Z(fp_Z),
    .ovrf(ovrf), .udrf(udrf), .zer(zer), .inf(inf), .nan(nan), .dz(dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [2:0]  rm;
    logic [31:0] z;
    logic [5:0]  fl;
    int          lat;
  } vec_t;

  vec_t vecs[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_lat(input string name, input int act, input int exp);
    n_checks++;
`ifdef FP_DIV_EARLY_EXIT_EN
    if (!(act <= exp && act >= 2)) begin
`else
    if (act != exp) begin
`endif
      n_errors++;
      $display("FAIL %s: latency got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one division and wait (bounded) for out_valid; lat counts edges after the accept edge.
  task automatic do_div(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm,
                        output logic [31:0] z, output logic [5:0] fl, output int lat);
    @(negedge clk);
    fp_X = x; fp_Y = y; r_mode = rm; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    z  = fp_Z;
    fl = {ovrf, udrf, zer, inf, nan, dz};
  endtask

  task automatic handshake(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({name, "_out_valid_low"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] z;
    logic [5:0]  fl;
    int          lat;
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    fp_X = 32'd0; fp_Y = 32'd0; r_mode = 3'd0;

    vecs[0]  = '{32'h40C00000, 32'h40400000, 3'b000, 32'h40000000, 6'b000000, 30};
    vecs[1]  = '{32'h3F800000, 32'h40400000, 3'b000, 32'h3EAAAAAB, 6'b000000, 30};
    vecs[2]  = '{32'h3F800000, 32'h40400000, 3'b001, 32'h3EAAAAAA, 6'b000000, 30};
    vecs[3]  = '{32'h3F800000, 32'h40400000, 3'b011, 32'h3EAAAAAB, 6'b000000, 30};
    vecs[4]  = '{32'h3F800000, 32'h40400000, 3'b010, 32'h3EAAAAAA, 6'b000000, 30};
    vecs[5]  = '{32'hBF800000, 32'h40400000, 3'b011, 32'hBEAAAAAA, 6'b000000, 30};
    vecs[6]  = '{32'hBF800000, 32'h40400000, 3'b010, 32'hBEAAAAAB, 6'b000000, 30};
    vecs[7]  = '{32'h3F800000, 32'h40400000, 3'b100, 32'h3EAAAAAB, 6'b000000, 30};
    vecs[8]  = '{32'h3F800000, 32'h40400000, 3'b111, 32'h3EAAAAAB, 6'b000000, 30};
    vecs[9]  = '{32'h3FC00000, 32'h3F000000, 3'b000, 32'h40400000, 6'b000000, 30};
    vecs[10] = '{32'hC0C00000, 32'h40400000, 3'b000, 32'hC0000000, 6'b000000, 30};
    vecs[11] = '{32'h3F800000, 32'h00000000, 3'b000, 32'h7F800000, 6'b000101, 2};
    vecs[12] = '{32'h80000000, 32'h80000000, 3'b000, 32'h7FC00000, 6'b000010, 2};
    vecs[13] = '{32'h00400000, 32'h3F800000, 3'b000, 32'h00000000, 6'b001000, 2};
    vecs[14] = '{32'h7FC00001, 32'h3F800000, 3'b000, 32'h7FC00000, 6'b000010, 2};
    vecs[15] = '{32'h7F800000, 32'hC0000000, 3'b000, 32'hFF800000, 6'b000100, 2};
    vecs[16] = '{32'h40000000, 32'h7F800000, 3'b000, 32'h00000000, 6'b001000, 2};
    vecs[17] = '{32'h7F000000, 32'h00800000, 3'b000, 32'h7F800000, 6'b100100, 30};
    vecs[18] = '{32'h7F000000, 32'h00800000, 3'b001, 32'h7F7FFFFF, 6'b100100, 30};
    vecs[19] = '{32'hFF000000, 32'h00800000, 3'b011, 32'hFF7FFFFF, 6'b100100, 30};
    vecs[20] = '{32'hFF000000, 32'h00800000, 3'b010, 32'hFF800000, 6'b100100, 30};
    vecs[21] = '{32'h00800000, 32'h7F000000, 3'b000, 32'h00000000, 6'b011000, 30};
    vecs[22] = '{32'h80800000, 32'h7F000000, 3'b000, 32'h80000000, 6'b011000, 30};

    repeat (3) @(negedge clk);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_fp_Z", fp_Z, 32'd0);
    chk("reset_flags", {26'd0, ovrf, udrf, zer, inf, nan, dz}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 23; i++) begin
      do_div(vecs[i].x, vecs[i].y, vecs[i].rm, z, fl, lat);
      chk($sformatf("vec%0d_z", i), z, vecs[i].z);
      chk($sformatf("vec%0d_flags", i), {26'd0, fl}, {26'd0, vecs[i].fl});
      chk_lat($sformatf("vec%0d", i), lat, vecs[i].lat);
      handshake($sformatf("vec%0d", i));
    end

    // Backpressure: result held while out_ready low, new start pulses ignored.
    do_div(32'h40C00000, 32'h40400000, 3'b000, z, fl, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'b1; fp_X = 32'h3F800000; fp_Y = 32'h40400000; r_mode = 3'b001;
      #1;
      chk($sformatf("bp%0d_z", i), fp_Z, 32'h40000000);
      chk($sformatf("bp%0d_flags", i), {26'd0, ovrf, udrf, zer, inf, nan, dz}, 32'd0);
      chk($sformatf("bp%0d_valid", i), {30'd0, out_valid, in_ready}, 32'd2);
    end
    @(negedge clk);
    start = 1'b0;
    handshake("bp");
    do_div(32'h3F800000, 32'h40400000, 3'b000, z, fl, lat);
    chk("after_bp_z", z, 32'h3EAAAAAB);
    chk_lat("after_bp", lat, 30);
    handshake("after_bp");

    // Reset mid-ITER aborts; outputs clear asynchronously.
    @(negedge clk);
    fp_X = 32'h40C00000; fp_Y = 32'h40400000; r_mode = 3'b000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_fp_Z", fp_Z, 32'd0);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_in_ready", {31'd0, in_ready}, 32'd1);
    do_div(32'h40C00000, 32'h40400000, 3'b000, z, fl, lat);
    chk("postrst_z", z, 32'h40000000);
    chk("postrst_flags", {26'd0, fl}, 32'd0);
    chk_lat("postrst", lat, 30);
    handshake("postrst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
